// File: rtl/vend_txn_controller.sv
// rtl/vend_txn_controller.sv - vending transaction controller: credit, product arbitration, dispense handshake, change
//
// Optional feature macro: VEND_TIMEOUT_EN (inactivity refund timer in CREDIT)
//
// Ports:
//   clk           in   single clock, rising edge
//   reset         in   asynchronous active-low reset
//   coin_5        in   5-unit coin pulse
//   coin_10       in   10-unit coin pulse
//   sel_a, sel_b  in   product selections, sampled every cycle
//   cancel        in   refund request
//   vend_done     in   dispenser finished the drop
//   vend_req_a/b  out  dispense request level, held until vend_done
//   change_5      out  one cycle high per 5 units returned
//   coin_reject   out  one-cycle pulse, coin not credited
//   credit        out  current credit
//   busy          out  high in VEND or CHANGE
//   current_state out  IDLE=0, CREDIT=1, VEND=2, CHANGE=3

module vend_txn_controller #(
  parameter int unsigned PRICE_A     = 15,
  parameter int unsigned PRICE_B     = 20,
  parameter int unsigned MAX_CREDIT  = 30,
  parameter int unsigned CREDIT_W    = 6,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_5,
  input  logic                coin_10,
  input  logic                sel_a,
  input  logic                sel_b,
  input  logic                cancel,
  input  logic                vend_done,
  output logic                vend_req_a,
  output logic                vend_req_b,
  output logic                change_5,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic [1:0]          current_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CREDIT = 2'd1,
    ST_VEND   = 2'd2,
    ST_CHANGE = 2'd3
  } state_t;

  localparam logic [CREDIT_W-1:0] PRICE_A_C = CREDIT_W'(PRICE_A);
  localparam logic [CREDIT_W-1:0] PRICE_B_C = CREDIT_W'(PRICE_B);
  localparam logic [CREDIT_W-1:0] MAX_C     = CREDIT_W'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] FIVE_C    = CREDIT_W'(5);
  localparam logic [CREDIT_W-1:0] TEN_C     = CREDIT_W'(10);

  localparam int unsigned       TMO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  state_t              state, state_nxt;
  logic [CREDIT_W-1:0] credit_nxt;
  logic                req_a_nxt, req_b_nxt, change_nxt, reject_nxt, busy_nxt;

  // Input decode shared by the next-state and output processes
  logic                in_credit;
  logic                coin_any, coin_both;
  logic [CREDIT_W-1:0] coin_val, coin_sum;
  logic                coin_fits;
  logic                cancel_ok, take_a, take_b, coin_ok, coin_rej;
  logic                tmo_hit, tmo_fire;

  assign in_credit = (state == ST_CREDIT);
  assign coin_any  = coin_5 | coin_10;
  assign coin_both = coin_5 & coin_10;
  assign coin_val  = coin_10 ? TEN_C : FIVE_C;
  // credit is at most MAX_CREDIT, so the sum never wraps within CREDIT_W
  assign coin_sum  = credit + coin_val;
  assign coin_fits = (coin_sum <= MAX_C);

  // Priority: cancel > sel_a > sel_b > coin. A select lacking credit
  // is dropped and lets the next lower-priority input through.
  assign cancel_ok = in_credit && cancel;
  assign take_a    = in_credit && !cancel && sel_a && (credit >= PRICE_A_C);
  assign take_b    = in_credit && !cancel && !take_a && sel_b && (credit >= PRICE_B_C);
  assign coin_ok   = coin_any && !coin_both && coin_fits &&
                     ((state == ST_IDLE) || (in_credit && !cancel_ok && !take_a && !take_b));
  assign coin_rej  = coin_any && !coin_ok;

  // Timeout only fires on a fully quiet CREDIT cycle
  assign tmo_fire  = in_credit && !cancel && !sel_a && !sel_b && !coin_any && tmo_hit;

  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_armed;

`ifdef VEND_TIMEOUT_EN
  logic in_activity;

  assign tmo_armed   = 1'b1;
  // Any coin (credited or not) and any select that did not vend restart the wait
  assign in_activity = coin_any | sel_a | sel_b;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt <= '0;
    end else if (in_credit && (state_nxt == ST_CREDIT) && !in_activity) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end else begin
      tmo_cnt <= '0;
    end
  end
`else
  assign tmo_armed = 1'b0;
  assign tmo_cnt   = '0;
`endif

  // Counter holds TIMEOUT_CYC-1 on the cycle whose increment would reach TIMEOUT_CYC
  assign tmo_hit = tmo_armed && (tmo_cnt == TMO_LAST);

  // State register; every output is registered alongside it so a reset
  // clears them (including vend_req_*) asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      credit      <= '0;
      vend_req_a  <= 1'b0;
      vend_req_b  <= 1'b0;
      change_5    <= 1'b0;
      coin_reject <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      credit      <= credit_nxt;
      vend_req_a  <= req_a_nxt;
      vend_req_b  <= req_b_nxt;
      change_5    <= change_nxt;
      coin_reject <= reject_nxt;
      busy        <= busy_nxt;
    end
  end

  assign current_state = state;

  // Next-state and credit
  always_comb begin
    state_nxt  = state;
    credit_nxt = credit;
    case (state)
      ST_IDLE: begin
        if (coin_ok) begin
          state_nxt  = ST_CREDIT;
          credit_nxt = coin_sum;
        end
      end
      ST_CREDIT: begin
        if (cancel_ok) begin
          state_nxt = ST_CHANGE;
        end else if (take_a) begin
          state_nxt  = ST_VEND;
          credit_nxt = credit - PRICE_A_C;
        end else if (take_b) begin
          state_nxt  = ST_VEND;
          credit_nxt = credit - PRICE_B_C;
        end else if (coin_ok) begin
          credit_nxt = coin_sum;
        end else if (tmo_fire) begin
          state_nxt = ST_CHANGE;
        end
      end
      ST_VEND: begin
        if (vend_done) begin
          state_nxt = (credit != '0) ? ST_CHANGE : ST_IDLE;
        end
      end
      ST_CHANGE: begin
        if (credit >= FIVE_C) begin
          credit_nxt = credit - FIVE_C;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt  = ST_IDLE;
        credit_nxt = '0;
      end
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    req_a_nxt  = 1'b0;
    req_b_nxt  = 1'b0;
    change_nxt = 1'b0;
    reject_nxt = coin_rej;
    busy_nxt   = (state_nxt == ST_VEND) || (state_nxt == ST_CHANGE);
    case (state)
      ST_CREDIT: begin
        req_a_nxt = take_a;
        req_b_nxt = take_b;
      end
      ST_VEND: begin
        req_a_nxt = vend_req_a && !vend_done;
        req_b_nxt = vend_req_b && !vend_done;
      end
      ST_CHANGE: begin
        change_nxt = (credit >= FIVE_C);
      end
      default: begin
        req_a_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_vend_txn_controller.sv
// tb/tb_vend_txn_controller.sv - self-checking bench for vend_txn_controller

module tb_vend_txn_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       coin_5 = 1'b0, coin_10 = 1'b0, sel_a = 1'b0, sel_b = 1'b0;
  logic       cancel = 1'b0, vend_done = 1'b0;
  logic       vend_req_a, vend_req_b, change_5, coin_reject, busy;
  logic [5:0] credit;
  logic [1:0] current_state;

  int n_checks = 0;
  int n_fail   = 0;

  vend_txn_controller #(
    .PRICE_A(15), .PRICE_B(20), .MAX_CREDIT(30), .CREDIT_W(6), .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk), .reset(reset),
    .coin_5(coin_5), .coin_10(coin_10), .sel_a(sel_a), .sel_b(sel_b),
    .cancel(cancel), .vend_done(vend_done),
    .vend_req_a(vend_req_a), .vend_req_b(vend_req_b), .change_5(change_5),
    .coin_reject(coin_reject), .credit(credit), .busy(busy),
    .current_state(current_state)
  );

  always #5 clk = ~clk;

  // inputs {coin_5, coin_10, sel_a, sel_b, cancel, vend_done}
  localparam logic [5:0] N   = 6'b000000;
  localparam logic [5:0] C5  = 6'b100000;
  localparam logic [5:0] C10 = 6'b010000;
  localparam logic [5:0] SA  = 6'b001000;
  localparam logic [5:0] SB  = 6'b000100;
  localparam logic [5:0] CN  = 6'b000010;
  localparam logic [5:0] VD  = 6'b000001;

  // outputs {vend_req_a, vend_req_b, change_5, coin_reject, busy}
  typedef struct {
    logic [5:0] in;
    logic [1:0] st;
    logic [5:0] cr;
    logic [4:0] outs;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [5:0] in, input logic [1:0] st,
                              input logic [5:0] cr, input logic [4:0] outs);
    vec_t t;
    t.in = in; t.st = st; t.cr = cr; t.outs = outs;
    return t;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // One cycle: drive at negedge, compare just after the following rising edge
  task automatic step(input string nm, input logic [5:0] in, input logic [1:0] st,
                      input logic [5:0] cr, input logic [4:0] outs);
    logic [12:0] act, exp;
    @(negedge clk);
    {coin_5, coin_10, sel_a, sel_b, cancel, vend_done} = in;
    @(posedge clk);
    #1;
    act = {current_state, credit, vend_req_a, vend_req_b, change_5, coin_reject, busy};
    exp = {st, cr, outs};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: state/credit/req_a,req_b,chg,rej,busy got %0d/%0d/%b expected %0d/%0d/%b",
               nm, act[12:11], act[10:5], act[4:0], exp[12:11], exp[10:5], exp[4:0]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int chg_cnt;

    // buy A with change
    vecs.push_back(mk(C10,     2'd1, 6'd10, 5'b00000));
    vecs.push_back(mk(C10,     2'd1, 6'd20, 5'b00000));
    vecs.push_back(mk(SA,      2'd2, 6'd5,  5'b10001));
    vecs.push_back(mk(N,       2'd2, 6'd5,  5'b10001));
    vecs.push_back(mk(VD,      2'd3, 6'd5,  5'b00001));
    vecs.push_back(mk(N,       2'd3, 6'd0,  5'b00101));
    vecs.push_back(mk(N,       2'd0, 6'd0,  5'b00000));
    // vend_done, selects and cancel are ignored in IDLE
    vecs.push_back(mk(VD,      2'd0, 6'd0,  5'b00000));
    vecs.push_back(mk(SA | CN, 2'd0, 6'd0,  5'b00000));
    // insufficient select, then cancel
    vecs.push_back(mk(C5,      2'd1, 6'd5,  5'b00000));
    vecs.push_back(mk(SB,      2'd1, 6'd5,  5'b00000));
    vecs.push_back(mk(CN,      2'd3, 6'd5,  5'b00001));
    vecs.push_back(mk(N,       2'd3, 6'd0,  5'b00101));
    vecs.push_back(mk(N,       2'd0, 6'd0,  5'b00000));
    // credit ceiling, coin rejected during CHANGE, six pulses for 30
    vecs.push_back(mk(C10,     2'd1, 6'd10, 5'b00000));
    vecs.push_back(mk(C10,     2'd1, 6'd20, 5'b00000));
    vecs.push_back(mk(C10,     2'd1, 6'd30, 5'b00000));
    vecs.push_back(mk(C5,      2'd1, 6'd30, 5'b00010));
    vecs.push_back(mk(N,       2'd1, 6'd30, 5'b00000));
    vecs.push_back(mk(CN,      2'd3, 6'd30, 5'b00001));
    vecs.push_back(mk(N,       2'd3, 6'd25, 5'b00101));
    vecs.push_back(mk(C5,      2'd3, 6'd20, 5'b00111));
    vecs.push_back(mk(N,       2'd3, 6'd15, 5'b00101));
    vecs.push_back(mk(N,       2'd3, 6'd10, 5'b00101));
    vecs.push_back(mk(N,       2'd3, 6'd5,  5'b00101));
    vecs.push_back(mk(N,       2'd3, 6'd0,  5'b00101));
    vecs.push_back(mk(N,       2'd0, 6'd0,  5'b00000));
    // both coins together
    vecs.push_back(mk(C10,     2'd1, 6'd10, 5'b00000));
    vecs.push_back(mk(C5 | C10,2'd1, 6'd10, 5'b00010));
    vecs.push_back(mk(N,       2'd1, 6'd10, 5'b00000));
    // simultaneous selects, coin during VEND
    vecs.push_back(mk(C10,     2'd1, 6'd20, 5'b00000));
    vecs.push_back(mk(SA | SB, 2'd2, 6'd5,  5'b10001));
    vecs.push_back(mk(C10,     2'd2, 6'd5,  5'b10011));
    vecs.push_back(mk(VD,      2'd3, 6'd5,  5'b00001));
    vecs.push_back(mk(N,       2'd3, 6'd0,  5'b00101));
    vecs.push_back(mk(N,       2'd0, 6'd0,  5'b00000));
    // exact price for B: no change, straight back to IDLE
    vecs.push_back(mk(C10,     2'd1, 6'd10, 5'b00000));
    vecs.push_back(mk(C10,     2'd1, 6'd20, 5'b00000));
    vecs.push_back(mk(SB,      2'd2, 6'd0,  5'b01001));
    vecs.push_back(mk(VD,      2'd0, 6'd0,  5'b00000));
    // coin alongside accepted cancel is rejected
    vecs.push_back(mk(C5,      2'd1, 6'd5,  5'b00000));
    vecs.push_back(mk(CN | C10,2'd3, 6'd5,  5'b00011));
    vecs.push_back(mk(N,       2'd3, 6'd0,  5'b00101));
    vecs.push_back(mk(N,       2'd0, 6'd0,  5'b00000));
    // coin alongside ignored select is credited
    vecs.push_back(mk(C5,      2'd1, 6'd5,  5'b00000));
    vecs.push_back(mk(SA | C5, 2'd1, 6'd10, 5'b00000));
    vecs.push_back(mk(CN,      2'd3, 6'd10, 5'b00001));
    vecs.push_back(mk(N,       2'd3, 6'd5,  5'b00101));
    vecs.push_back(mk(N,       2'd3, 6'd0,  5'b00101));
    vecs.push_back(mk(N,       2'd0, 6'd0,  5'b00000));
    // both coins in IDLE
    vecs.push_back(mk(C5 | C10,2'd0, 6'd0,  5'b00010));
    vecs.push_back(mk(N,       2'd0, 6'd0,  5'b00000));

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          {19'd0, current_state, credit, vend_req_a, vend_req_b, change_5, coin_reject, busy},
          32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("vec%0d", i), vecs[i].in, vecs[i].st, vecs[i].cr, vecs[i].outs);
    end

    // reset mid-VEND with credit 15
    step("rst_c10a", C10, 2'd1, 6'd10, 5'b00000);
    step("rst_c10b", C10, 2'd1, 6'd20, 5'b00000);
    step("rst_c10c", C10, 2'd1, 6'd30, 5'b00000);
    step("rst_sela", SA,  2'd2, 6'd15, 5'b10001);
    @(negedge clk);
    {coin_5, coin_10, sel_a, sel_b, cancel, vend_done} = N;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_outputs",
          {19'd0, current_state, credit, vend_req_a, vend_req_b, change_5, coin_reject, busy},
          32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    chg_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (change_5) chg_cnt++;
    end
    check("post_reset_change_count", chg_cnt, 0);
    check("post_reset_state_credit", {current_state, credit}, {2'd0, 6'd0});

`ifdef VEND_TIMEOUT_EN
    step("tmo_coin", C10, 2'd1, 6'd10, 5'b00000);
    for (int i = 1; i < 8; i++) begin
      step($sformatf("tmo_wait%0d", i), N, 2'd1, 6'd10, 5'b00000);
    end
    step("tmo_fire",  N, 2'd3, 6'd10, 5'b00001);
    step("tmo_chg1",  N, 2'd3, 6'd5,  5'b00101);
    step("tmo_chg2",  N, 2'd3, 6'd0,  5'b00101);
    step("tmo_idle",  N, 2'd0, 6'd0,  5'b00000);
`else
    step("notmo_coin", C10, 2'd1, 6'd10, 5'b00000);
    for (int i = 0; i < 100; i++) begin
      step($sformatf("notmo_wait%0d", i), N, 2'd1, 6'd10, 5'b00000);
    end
    step("notmo_cancel", CN, 2'd3, 6'd10, 5'b00001);
    step("notmo_chg1",   N,  2'd3, 6'd5,  5'b00101);
    step("notmo_chg2",   N,  2'd3, 6'd0,  5'b00101);
    step("notmo_idle",   N,  2'd0, 6'd0,  5'b00000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vend_txn_controller.md
# vend_txn_controller

Transaction controller for the vending machine. It accumulates credit from 5- and 10-unit coin pulses, arbitrates between two product selections, and drives a request/done handshake to the product dispenser. It then returns change as 5-unit pulses. It sits between the coin acceptor/keypad inputs and the dispenser mechanism, and replaces the fixed single-price vend FSM.

## Interface
- `PRICE_A`, default 15: price of product A, in units. Multiple of 5, at most `MAX_CREDIT`.
- `PRICE_B`, default 20: price of product B, in units. Multiple of 5, at most `MAX_CREDIT`.
- `MAX_CREDIT`, default 30: credit ceiling. Multiple of 5.
- `CREDIT_W`, default 6: credit register width. Must hold `MAX_CREDIT + 10`.
- `TIMEOUT_CYC`, default 1000: inactivity timeout in clock cycles. Used only when `VEND_TIMEOUT_EN` is defined.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous assert, active-low; release is synchronous to `clk` externally.
- `coin_5` in 1: 5-unit coin, one-cycle pulse.
- `coin_10` in 1: 10-unit coin, one-cycle pulse.
- `sel_a` in 1: select product A, sampled per cycle.
- `sel_b` in 1: select product B, sampled per cycle.
- `cancel` in 1: refund request.
- `vend_done` in 1: dispenser has completed the drop.
- `vend_req_a` out 1: dispense A; level, held until done.
- `vend_req_b` out 1: dispense B; level, held until done.
- `change_5` out 1: high one cycle per 5 units returned.
- `coin_reject` out 1: one-cycle pulse; coin not credited and must be returned by the acceptor.
- `credit` out `CREDIT_W`: current credit.
- `busy` out 1: high in VEND or CHANGE.
- `current_state` out 2: IDLE=0, CREDIT=1, VEND=2, CHANGE=3.

## Operation
- All outputs are registered.
- Reset value of every output is 0; state resets to IDLE and credit to 0. Reset mid-transaction discards credit with no change issued; `vend_req_*` drops immediately (asynchronously).
- In IDLE and CREDIT, per-cycle input priority is `cancel` > `sel_a` > `sel_b` > coin.
- IDLE:
  - An accepted coin moves to CREDIT with credit = coin value.
  - `sel_*` and `cancel` are ignored.
- CREDIT:
  - A coin is accepted if credit + value ≤ `MAX_CREDIT`; otherwise `coin_reject` fires and credit is unchanged.
  - `sel_a` with credit ≥ `PRICE_A` moves to VEND: credit −= `PRICE_A`, `vend_req_a` = 1. `sel_b` behaves the same with `PRICE_B`.
  - A select with insufficient credit is ignored, with no state change.
  - `cancel` moves to CHANGE.
- VEND:
  - `vend_req_x` holds until `vend_done` is sampled high.
  - On `vend_done`, the block goes to CHANGE if credit > 0, otherwise to IDLE.
  - `vend_done` seen in any other state is ignored.
- CHANGE:
  - Each cycle with credit ≥ 5, `change_5` = 1 and credit −= 5.
  - When credit reaches 0, the block goes to IDLE and `change_5` = 0 that cycle.
- Rejections:
  - Any coin in VEND or CHANGE is rejected.
  - A coin arriving in the same cycle as an accepted `cancel` or select is rejected.
  - `coin_5` and `coin_10` high together are both rejected, with a single `coin_reject` pulse.

## Timing
- Coin sampled at edge k: `credit` and `current_state` update at edge k; `coin_reject` is high during cycle k+1 only.
- Select sampled at edge k: `vend_req_x` is high from edge k, and credit is debited at edge k.
- `vend_done` sampled at edge k: `vend_req_x` is low from edge k. The dispenser must hold `vend_done` until it sees `vend_req_x` low.
- Change is paid out as credit/5 consecutive `change_5` cycles, starting the cycle after entry to CHANGE. The return to IDLE happens on the edge after the last pulse.
- `busy` equals (`current_state` == VEND || `current_state` == CHANGE), registered together with the state.

## Configuration
- `VEND_TIMEOUT_EN` defined:
  - A counter of `clog2(TIMEOUT_CYC+1)` bits runs in CREDIT. It clears on every accepted or rejected coin and on every ignored select.
  - When it reaches `TIMEOUT_CYC`, the block goes to CHANGE and refunds all credit.
  - The counter is held at 0 outside CREDIT.
- `VEND_TIMEOUT_EN` undefined: no counter is built, and CREDIT persists indefinitely until `cancel` or a select.

## Test plan
- `coin_10`, `coin_10`, `sel_a` → `vend_req_a` = 1 and credit 20 → 5; `vend_done` → one `change_5` pulse, then IDLE with credit 0.
- `coin_5`, `sel_b` → ignored, credit stays 5 in CREDIT; `cancel` → one `change_5` pulse, then IDLE.
- Credit 30, then `coin_5` → `coin_reject` for one cycle, credit stays 30; `coin_5` + `coin_10` together at credit 10 → one reject, credit 10.
- Credit 20, `sel_a` and `sel_b` in the same cycle → only `vend_req_a`, credit 5; `coin_10` during VEND → rejected.
- `reset` driven low mid-VEND (credit 15) → all outputs 0 immediately, IDLE after release, no `change_5` ever.
- With `VEND_TIMEOUT_EN` and `TIMEOUT_CYC` = 8: `coin_10`, then 8 idle cycles → CHANGE, two `change_5` cycles, then IDLE. Without the macro, credit stays 10 after 100 idle cycles.
